// File: rtl/fp_div.sv
// Iterative IEEE-754 single-precision divider: restoring loop, one quotient bit per clock.
// Define FP_DIV_ROUND_EN to add a guard iteration and round-to-nearest-even; truncation otherwise.
module fp_div #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned MANT_W = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [EXP_W+MANT_W:0] a,
    input  logic [EXP_W+MANT_W:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [EXP_W+MANT_W:0] result,
    output logic                  div_by_zero
);
    localparam int unsigned W  = EXP_W + MANT_W + 1;
    localparam int unsigned XW = EXP_W + 2;
    localparam int unsigned MW = MANT_W + 1;
    localparam int unsigned RW = MANT_W + 2;
    localparam int unsigned FW = MANT_W + 1;
`ifdef FP_DIV_ROUND_EN
    localparam int unsigned QW = MANT_W + 3;
`else
    localparam int unsigned QW = MANT_W + 2;
`endif
    localparam int unsigned CW = $clog2(QW + 1);
    localparam logic [CW-1:0]        LAST    = CW'(QW - 1);
    localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] ONE_X   = XW'(1);
    localparam logic signed [XW-1:0] ZERO_X  = '0;
    localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         rem_q, rem_d;
    logic [QW-1:0]         quo_q, quo_d;
    logic [MW-1:0]         mb_q, mb_d;
    logic signed [XW-1:0]  exp_q, exp_d;
    logic                  sign_q, sign_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [W-1:0]          result_q, result_d;
    logic                  dbz_q, dbz_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic [EXP_W-1:0]      ea, eb;
    logic [MANT_W-1:0]     fa, fb;
    logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_x;
    logic                  is_special, spec_dbz, accept, q_bit;
    logic [W-1:0]          spec_res, norm_res;
    logic [RW-1:0]         rem_sub;
    logic signed [XW-1:0]  exp_n;
    logic [MANT_W-1:0]     frac_n;
`ifdef FP_DIV_ROUND_EN
    logic                  guard, sticky;
    logic [FW-1:0]         frac_rnd;
`endif

    assign ea     = a[W-2:MANT_W];
    assign eb     = b[W-2:MANT_W];
    assign fa     = a[MANT_W-1:0];
    assign fb     = b[MANT_W-1:0];
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (&ea) && (fa == '0);
    assign b_inf  = (&eb) && (fb == '0);
    assign a_nan  = (&ea) && (fa != '0);
    assign b_nan  = (&eb) && (fb != '0);
    assign sign_x = a[W-1] ^ b[W-1];
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Single-cycle resolution of zero/Inf/NaN operands (denormals treated as zero)
    always_comb begin
        is_special = 1'b1;
        spec_dbz   = 1'b0;
        spec_res   = QNAN;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_res = QNAN;
        end else if (a_inf) begin
            spec_res = {sign_x, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (b_inf || a_zero) begin
            spec_res = {sign_x, {(W-1){1'b0}}};
        end else if (b_zero) begin
            spec_res = {sign_x, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            spec_dbz = 1'b1;
        end else begin
            is_special = 1'b0;
        end
    end

    // Normalise the quotient, optionally round, then clamp the exponent range
    always_comb begin
        exp_n = exp_q;
`ifdef FP_DIV_ROUND_EN
        if (quo_q[QW-1]) begin
            frac_n = quo_q[QW-2:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (|rem_q);
        end else begin
            frac_n = quo_q[QW-3:1];
            guard  = quo_q[0];
            sticky = |rem_q;
            exp_n  = exp_q - ONE_X;
        end
        frac_rnd = {1'b0, frac_n} + FW'(guard & (sticky | frac_n[0]));
        if (frac_rnd[MANT_W]) begin
            exp_n = exp_n + ONE_X;
        end
        frac_n = frac_rnd[MANT_W-1:0];
`else
        if (quo_q[QW-1]) begin
            frac_n = quo_q[QW-2:1];
        end else begin
            frac_n = quo_q[QW-3:0];
            exp_n  = exp_q - ONE_X;
        end
`endif
        if (exp_n >= EXP_MAX) begin
            norm_res = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (exp_n <= ZERO_X) begin
            norm_res = {sign_q, {(W-1){1'b0}}};
        end else begin
            norm_res = {sign_q, exp_n[EXP_W-1:0], frac_n};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = is_special ? S_DONE : S_DIVIDE;
            S_DIVIDE: if (cnt_q == LAST) state_d = S_NORM;
            S_NORM:   state_d = S_DONE;
            S_DONE:   state_d = start ? (is_special ? S_DONE : S_DIVIDE) : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rem_d    = rem_q;
        quo_d    = quo_q;
        mb_d     = mb_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        busy_d   = (state_d == S_DIVIDE) || (state_d == S_NORM);
        done_d   = (state_d == S_DONE);
        q_bit    = (rem_q >= RW'(mb_q));
        rem_sub  = q_bit ? (rem_q - RW'(mb_q)) : rem_q;
        if (accept) begin
            dbz_d = spec_dbz;
            if (is_special) begin
                result_d = spec_res;
            end else begin
                rem_d  = RW'({1'b1, fa});
                mb_d   = {1'b1, fb};
                quo_d  = '0;
                cnt_d  = '0;
                exp_d  = $signed(XW'(ea)) - $signed(XW'(eb)) + BIAS;
                sign_d = sign_x;
            end
        end else if (state_q == S_DIVIDE) begin
            rem_d = rem_sub << 1;
            quo_d = {quo_q[QW-2:0], q_bit};
            cnt_d = cnt_q + CW'(1);
        end else if (state_q == S_NORM) begin
            result_d = norm_res;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q    <= '0;
            quo_q    <= '0;
            mb_q     <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            mb_q     <= mb_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div: arithmetic reference model with per-cycle compare plus directed vectors.
module tb_fp_div;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

`ifdef FP_DIV_ROUND_EN
    localparam int          LAT   = 28;
    localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
    localparam int          LAT   = 27;
    localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

    always #5 clk = ~clk;

    fp_div dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    typedef struct packed {
        logic [31:0] r;
        logic        dz;
        logic        sp;
    } mres_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Quotient by integer division of scaled mantissas, then normalise/round/clamp
    function automatic mres_t model_div(input logic [31:0] x, input logic [31:0] y);
        mres_t  o;
        int     ex, ey, e, k, nl;
        longint mx, my, q, mant;
        logic   s;
        bit     xn, yn, xi, yi, xz, yz;
`ifdef FP_DIV_ROUND_EN
        longint rm, lost;
        bit     g, st;
`endif
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        o.r  = 32'h7FC00000;
        o.dz = 1'b0;
        o.sp = 1'b1;
        if (xn || yn)                      o.r = 32'h7FC00000;
        else if ((xi && yi) || (xz && yz)) o.r = 32'h7FC00000;
        else if (xi)                       o.r = {s, 8'hFF, 23'h0};
        else if (yi || xz)                 o.r = {s, 31'h0};
        else if (yz) begin
            o.r  = {s, 8'hFF, 23'h0};
            o.dz = 1'b1;
        end else begin
            o.sp = 1'b0;
            mx = longint'({1'b1, x[22:0]});
            my = longint'({1'b1, y[22:0]});
`ifdef FP_DIV_ROUND_EN
            k = 25;
`else
            k = 24;
`endif
            q = (mx << k) / my;
            e = ex - ey + 127;
            if (q[k]) begin
                nl = k - 23;
            end else begin
                nl = k - 24;
                e  = e - 1;
            end
            mant = q >> nl;
`ifdef FP_DIV_ROUND_EN
            rm   = (mx << k) % my;
            lost = q & ((longint'(1) << nl) - 1);
            g    = lost[nl-1];
            st   = (rm != 0) || ((lost & ((longint'(1) << (nl - 1)) - 1)) != 0);
            if (g && (st || mant[0])) mant = mant + 1;
            if (mant == (longint'(1) << 24)) begin
                mant = longint'(1) << 23;
                e    = e + 1;
            end
`endif
            if (e >= 255)    o.r = {s, 8'hFF, 23'h0};
            else if (e <= 0) o.r = {s, 31'h0};
            else             o.r = {s, e[7:0], mant[22:0]};
        end
        return o;
    endfunction

    mres_t       m_nx;
    bit          m_busy, m_done, m_dbz;
    logic [31:0] m_res, m_pend;
    int          m_left;

    assign m_nx = model_div(a, b);

    // Transaction-level timing model: accept when not busy, fixed latency per operand class
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            m_res  <= '0;
            m_pend <= '0;
            m_left <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_res  <= m_pend;
            end
        end else if (start) begin
            m_dbz <= m_nx.dz;
            if (m_nx.sp) begin
                m_done <= 1'b1;
                m_res  <= m_nx.r;
            end else begin
                m_done <= 1'b0;
                m_busy <= 1'b1;
                m_left <= LAT - 1;
                m_pend <= m_nx.r;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_busy));
            check("cyc_done", 32'(done), 32'(m_done));
            if (!m_busy) begin
                check("cyc_result", result, m_res);
                check("cyc_dbz", 32'(div_by_zero), 32'(m_dbz));
            end
        end
    end

    task automatic launch(input logic [31:0] ia, input logic [31:0] ib);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string name, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] er, input logic edz, input int elat);
        mres_t mr;
        int    lat;
        mr = model_div(ia, ib);
        check({name, "_model"}, mr.r, er);
        @(negedge clk);
        launch(ia, ib);
        wait_done(lat);
        check({name, "_lat"}, 32'(lat), 32'(elat));
        check({name, "_res"}, result, er);
        check({name, "_dbz"}, 32'(div_by_zero), 32'(edz));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_dbz", 32'(div_by_zero), 32'h0);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;

        run("div_6_2",    32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LAT);
        run("div_1_3",    32'h3F800000, 32'h40400000, THIRD,        1'b0, LAT);
        run("div_m75_25", 32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, LAT);
        run("x_div_0",    32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1);
        run("0_div_0",    32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1);
        run("inf_div_2",  32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1);
        run("m2_div_inf", 32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0, 1);
        run("nan_div_1",  32'hFFC12345, 32'h3F800000, 32'h7FC00000, 1'b0, 1);
        run("ovf",        32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, LAT);
        run("unf",        32'h00800000, 32'h40000000, 32'h00000000, 1'b0, LAT);
        run("denorm",     32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1);

        // Start while busy must be ignored
        @(negedge clk);
        launch(32'h40C00000, 32'h40000000);
        lat = 1;
        while (!done && lat < 60) begin
            if (lat == 5) begin
                a     = 32'h3F800000;
                b     = 32'h40400000;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
        end
        check("ign_lat", 32'(lat), 32'(LAT));
        check("ign_res", result, 32'h40400000);
        repeat (2) @(posedge clk);

        // Back-to-back issue in the done cycle
        @(negedge clk);
        launch(32'h40C00000, 32'h40000000);
        wait_done(lat);
        check("b2b1_res", result, 32'h40400000);
        launch(32'hC0F00000, 32'h40200000);
        check("b2b_done_drop", 32'(done), 32'h0);
        wait_done(lat);
        check("b2b2_lat", 32'(lat), 32'(LAT));
        check("b2b2_res", result, 32'hC0400000);
        repeat (2) @(posedge clk);

        // Asynchronous reset mid-divide
        @(negedge clk);
        launch(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_result", result, 32'h0);
        check("arst_dbz", 32'(div_by_zero), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        run("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, LAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fp_div.md
Name: fp_div

Overview:
- Iterative IEEE-754 single-precision divider; the inverse operation of the team's combinational FP multiplier.
- Sits beside the multiplier in the FP execute path. Multi-cycle: the issue stage raises start, then waits for done.
- Quotient mantissa comes from a restoring shift/subtract loop, one quotient bit per clock.
- Special operands (zero, Inf, NaN, denormal) resolve in a single cycle.

Parameters:
- EXP_W, 8: exponent field width. Bias is 2^(EXP_W-1)-1.
- MANT_W, 23: stored fraction width. Hidden bit is added internally.
- Only the defaults (8/23) are verified.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request pulse; sampled only when accepting (IDLE or DONE)
- a  input  32  dividend, IEEE-754 single
- b  input  32  divisor, IEEE-754 single
- busy  output  1  high in DIVIDE and NORM
- done  output  1  one-cycle pulse; result is valid from this cycle
- result  output  32  quotient; held until the next accepted start
- div_by_zero  output  1  set with done when b is zero and a is finite non-zero; held with result

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, result=0, done=0, busy=0, div_by_zero=0, internal counter/remainder=0. This applies mid-operation as well; the aborted divide is discarded.
- States: IDLE, DIVIDE, NORM, DONE.
- Operand latch: on an accepted start, a and b are captured. Later changes on a and b have no effect.
- Special-case decode, done on the accepting edge; the FSM goes straight to DONE (done high one cycle after start):
  - Denormal inputs (exp==0) are flushed to signed zero.
  - Either operand NaN -> 0x7FC00000.
  - Inf/Inf or 0/0 -> 0x7FC00000.
  - Inf/finite -> signed Inf.
  - finite/Inf -> signed zero.
  - 0/non-zero -> signed zero.
  - non-zero finite/0 -> signed Inf, and div_by_zero=1.
  - Sign is always a[31]^b[31], except for NaN, which uses sign 0.
- Normal path:
  - Accepting edge: load ma={1,a frac}, mb={1,b frac}, remainder=ma, count=0. Compute signed exp_tmp = ea - eb + bias as a 10-bit signed value. Go to DIVIDE.
  - DIVIDE: each edge does:
    - q_bit = (rem >= mb);
    - rem = (q_bit ? rem-mb : rem) << 1;
    - Q = {Q, q_bit};
    - count++.
  - DIVIDE runs 25 iterations, then goes to NORM.
  - NORM:
    - If Q[24]=1: frac=Q[23:1], exp=exp_tmp.
    - Else: frac=Q[22:0], exp=exp_tmp-1.
    - Truncation only (no rounding).
    - exp>=255 -> signed Inf.
    - exp<=0 -> signed zero (flush; no subnormal output).
    - Register result, go to DONE.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - Without start: go to IDLE next edge.
  - With start: accept the new operands (back-to-back issue), and done drops.
- Latency: normal operands give done 27 cycles after the start-sampling edge (1 load + 25 iterate + 1 normalise). Special cases give 1 cycle.
- start while busy is ignored; there is no queuing.
- div_by_zero clears on the next accepted start.

Optional Feature:
- Macro: FP_DIV_ROUND_EN.
- Defined:
  - DIVIDE runs 26 iterations (an extra guard bit); normal latency becomes 28.
  - sticky = (final remainder != 0).
  - Round-to-nearest-even on {guard, sticky, lsb}.
  - If mantissa rounding carries out, exp+1 and frac=0; the overflow check is applied after rounding.
- Undefined: truncation as above, 25 iterations.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000, start one cycle -> result=0x40400000, done exactly 27 cycles after the start edge, busy high in between, div_by_zero=0.
- 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAA (truncating); 0x3EAAAAAB with FP_DIV_ROUND_EN. Also -7.5/2.5: 0xC0F00000 / 0x40200000 -> 0xC0400000.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1, done 1 cycle after start.
  - 0x00000000 / 0x00000000 -> 0x7FC00000, div_by_zero=0.
  - 0x7F800000 / 0x40000000 -> 0x7F800000.
  - 0xC0000000 / 0x7F800000 -> 0x80000000.
- Range: 0x7F000000 / 0x00800000 -> 0x7F800000 (overflow). 0x00800000 / 0x40000000 -> 0x00000000 (underflow flush). 0x00400000 (denormal) / 0x3F800000 -> 0x00000000.
- Handshake:
  - Pulse start again at iteration 5 with different operands -> ignored, first result returned.
  - Start in the DONE cycle -> second operation accepted, its result correct 27 cycles later.
- Reset: drive reset low at DIVIDE iteration 10 -> all outputs 0 asynchronously, state IDLE. After release, 6.0/2.0 still returns 0x40400000.
